pipe_skid_latch: RTL and testbench
==================================

PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64: payload width in bits.
REQ-002 The block SHALL have parameter CTRL_W, default 16: control-bit width.
REQ-003 The block SHALL have parameter REQ_MASK, CTRL_W bits, default 16'h0003: control bits that are memory requests (dREN/dWEN), cleared on dhit while held.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept a beat this cycle.
REQ-008 The block SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-009 The block SHALL have port in_ctrl, input, CTRL_W bits: upstream control bits.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all held and incoming beats.
REQ-011 The block SHALL have port dhit, input, 1 bit: data-memory hit for the beat at the output.
REQ-012 The block SHALL have port out_valid, output, 1 bit: downstream beat present.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-014 The block SHALL have port out_data, output, DATA_W bits: head payload.
REQ-015 The block SHALL have port out_ctrl, output, CTRL_W bits: head control bits.
REQ-016 The block SHALL have port occupancy, output, 2 bits: number of held beats, 0 to 2.

Function
REQ-017 Storage SHALL be two entries: main (drives outputs) and skid; FSM states EMPTY, ONE, TWO.
REQ-018 Accept SHALL occur when in_valid and in_ready; pop SHALL occur when out_valid and out_ready.
REQ-019 in_ready SHALL equal (state != TWO) and SHALL depend only on registered state.
REQ-020 out_valid SHALL be 1 exactly in ONE and TWO; out_data and out_ctrl SHALL be all-zero in EMPTY.
REQ-021 EMPTY with accept SHALL load main and go to ONE; latency input-to-output is one cycle.
REQ-022 ONE with accept and no pop SHALL load skid and go to TWO.
REQ-023 ONE with accept and pop SHALL load main with the new beat and stay in ONE.
REQ-024 ONE with pop only SHALL go to EMPTY and zero main.
REQ-025 TWO with pop SHALL move skid to main, zero skid and go to ONE; no accept is possible in TWO.
REQ-026 With no accept and no pop, all entries SHALL hold unchanged; this is the stall case.
REQ-027 Beats SHALL leave in arrival order; no beat SHALL be duplicated or dropped except by flush.
REQ-028 flush SHALL take priority over all events: both entries zeroed, state EMPTY, same-cycle input beat dropped, same-cycle pop still counted by downstream.
REQ-029 When out_valid and dhit and not out_ready, main ctrl bits set in REQ_MASK SHALL be cleared next edge; other bits and data SHALL be held.
REQ-030 dhit SHALL have no effect on the skid entry, in EMPTY, or in a cycle with pop or flush.
REQ-031 occupancy SHALL equal 0, 1, 2 for EMPTY, ONE, TWO.

Reset
REQ-032 nRST low SHALL immediately force state EMPTY, both entries zero, out_valid 0, in_ready 1, occupancy 0, independent of CLK, including mid-transfer.
REQ-033 The first accept after reset release SHALL be possible on the first rising CLK edge with nRST high.

Structure
REQ-034 The state enum (EMPTY, ONE, TWO) SHALL live in the shared cpu_types_pkg.
REQ-035 One sub-module, pipe_entry (DATA_W+CTRL_W register with load, clear and mask-clear), SHALL be instantiated twice.

Verification
REQ-036 Scenario 1: push data 0xA, ctrl 0x0004 with out_ready=1 -> out_valid=1 next cycle, out_data 0xA, occupancy 1.
REQ-037 Scenario 2: out_ready=0, push 0x1 then 0x2 -> occupancy 2, in_ready 0; raise out_ready -> 0x1 then 0x2 out in order.
REQ-038 Scenario 3: head ctrl 0x0003, out_ready=0, dhit=1 -> next cycle out_ctrl 0x0000, out_data unchanged.
REQ-039 Scenario 4: state TWO plus flush with in_valid=1 -> next cycle occupancy 0, out_valid 0, in_ready 1, outputs zero.
REQ-040 Scenario 5: assert nRST low between edges while in TWO -> out_valid 0 and occupancy 0 immediately without any CLK edge.
REQ-041 Scenario 6: ONE with simultaneous accept 0x5 and pop -> state ONE, out_data 0x5 next cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: latch occupancy states and a helper mapping them to a beat count.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  function automatic logic [1:0] occ_of(input skid_state_t s);
    case (s)
      ONE:     occ_of = 2'd1;
      TWO:     occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_latch_if.sv
// Upstream/downstream handshake bundle of the skid latch; slave is the latch side.
interface pipe_skid_latch_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              dhit;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_data, in_ctrl, flush, dhit, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, flush, dhit, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );
endinterface

// File: rtl/pipe_entry.sv
// One held beat: clear beats load, load beats mask-clear of the request bits.
module pipe_entry #(
  parameter int unsigned    W    = 80,
  parameter logic [W-1:0]   MASK = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic         mask_clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        q <= '0;
    else if (clear)    q <= '0;
    else if (load)     q <= d;
    else if (mask_clr) q <= q & ~MASK;
  end

endmodule

// File: rtl/pipe_skid_latch.sv
// Two-entry skid latch between pipeline stages; main drives the outputs, skid absorbs one stalled beat.
module pipe_skid_latch
  import cpu_types_pkg::*;
#(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] REQ_MASK = {{(CTRL_W-2){1'b0}}, 2'b11}
) (
  input  logic               CLK,
  input  logic               nRST,
  pipe_skid_latch_if.slave   bus
);

  localparam int unsigned  W         = DATA_W + CTRL_W;
  localparam logic [W-1:0] FULL_MASK = {{DATA_W{1'b0}}, REQ_MASK};

  skid_state_t  state;
  logic         accept, pop;
  logic         main_load, main_clr, main_mask, skid_load, skid_clr;
  logic [W-1:0] in_beat, main_d, main_q, skid_q;

  assign in_beat       = {bus.in_data, bus.in_ctrl};
  assign bus.in_ready  = (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_data  = main_q[W-1:CTRL_W];
  assign bus.out_ctrl  = main_q[CTRL_W-1:0];
  assign bus.occupancy = occ_of(state);

  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    main_mask = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    main_d    = in_beat;
    if (bus.flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        EMPTY: main_load = accept;
        ONE: begin
          skid_load = accept && !pop;
          main_load = accept && pop;
          main_clr  = !accept && pop;
          main_mask = bus.dhit && !pop;
        end
        TWO: begin
          // skid advances into main; main's own mask-clear is moot on a pop
          main_load = pop;
          main_d    = skid_q;
          skid_clr  = pop;
          main_mask = bus.dhit && !pop;
        end
        default: main_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= EMPTY;
    end else if (bus.flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state <= ONE;
        ONE: begin
          if (accept && !pop)      state <= TWO;
          else if (!accept && pop) state <= EMPTY;
        end
        TWO:     if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  pipe_entry #(.W(W), .MASK(FULL_MASK)) u_main (
    .clk      (CLK),
    .rst_n    (nRST),
    .load     (main_load),
    .clear    (main_clr),
    .mask_clr (main_mask),
    .d        (main_d),
    .q        (main_q)
  );

  pipe_entry #(.W(W), .MASK(FULL_MASK)) u_skid (
    .clk      (CLK),
    .rst_n    (nRST),
    .load     (skid_load),
    .clear    (skid_clr),
    .mask_clr (1'b0),
    .d        (in_beat),
    .q        (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Bench for pipe_skid_latch: directed scenarios then random traffic against a FIFO-queue reference model.
module tb_pipe_skid_latch;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] MASK = 16'h0003;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  logic CLK;
  logic nRST;
  int   n_cmp;
  int   n_err;
  beat_t q[$];

  pipe_skid_latch_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_skid_latch #(.DATA_W(DW), .CTRL_W(CW), .REQ_MASK(MASK)) u_dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    chk("in_ready",  64'(bus.in_ready),  64'(q.size() < 2));
    chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
    chk("out_data",  bus.out_data,       (q.size() > 0) ? q[0].d : 64'h0);
    chk("out_ctrl",  64'(bus.out_ctrl),  64'((q.size() > 0) ? q[0].c : 16'h0));
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic fl, input logic dh, input logic ordy);
    logic acc, pp;
    beat_t b;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.flush     = fl;
    bus.dhit      = dh;
    bus.out_ready = ordy;
    acc = v && (q.size() < 2);
    pp  = ordy && (q.size() > 0);
    @(posedge CLK);
    if (fl) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      else if (dh && q.size() > 0) q[0].c = q[0].c & ~MASK;
      if (acc) begin
        b.d = d;
        b.c = c;
        q.push_back(b);
      end
    end
    @(negedge CLK);
    check_model();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    nRST = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ctrl = '0;
    bus.flush = 1'b0; bus.dhit = 1'b0; bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_occ",       64'(bus.occupancy), 64'd0);
    chk("rst_out_data",  bus.out_data,       64'd0);
    #6 nRST = 1'b1;
    @(negedge CLK);

    // Scenario 1: single beat, one-cycle latency
    cycle(1'b1, 64'hA, 16'h0004, 1'b0, 1'b0, 1'b1);
    chk("s1_valid", 64'(bus.out_valid), 64'd1);
    chk("s1_data",  bus.out_data,       64'hA);
    chk("s1_occ",   64'(bus.occupancy), 64'd1);
    idle(1'b1);

    // Scenario 2: fill both entries, then drain in order
    cycle(1'b1, 64'h1, 16'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h2, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("s2_occ",   64'(bus.occupancy), 64'd2);
    chk("s2_ready", 64'(bus.in_ready),  64'd0);
    chk("s2_head1", bus.out_data,       64'h1);
    cycle(1'b1, 64'h99, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("s2_head2", bus.out_data,       64'h2);
    idle(1'b1);
    chk("s2_empty", 64'(bus.out_valid), 64'd0);

    // Scenario 3: dhit while stalled clears only the request bits
    cycle(1'b1, 64'h77, 16'h0003, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("s3_ctrl", 64'(bus.out_ctrl), 64'h0);
    chk("s3_data", bus.out_data,      64'h77);

    // Scenario 6: simultaneous accept and pop in ONE
    cycle(1'b1, 64'h5, 16'h8001, 1'b0, 1'b1, 1'b1);
    chk("s6_occ",  64'(bus.occupancy), 64'd1);
    chk("s6_data", bus.out_data,       64'h5);
    chk("s6_ctrl", 64'(bus.out_ctrl),  64'h8001);

    // Scenario 4: flush from TWO drops the same-cycle input beat
    cycle(1'b1, 64'h6, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("s4_pre_occ", 64'(bus.occupancy), 64'd2);
    cycle(1'b1, 64'hDEAD, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    chk("s4_occ",   64'(bus.occupancy), 64'd0);
    chk("s4_valid", 64'(bus.out_valid), 64'd0);
    chk("s4_ready", 64'(bus.in_ready),  64'd1);
    chk("s4_data",  bus.out_data,       64'd0);
    chk("s4_ctrl",  64'(bus.out_ctrl),  64'd0);

    // Scenario 5: asynchronous reset between edges while in TWO
    cycle(1'b1, 64'h11, 16'h1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h22, 16'h2, 1'b0, 1'b0, 1'b0);
    chk("s5_pre_occ", 64'(bus.occupancy), 64'd2);
    bus.in_valid = 1'b0;
    #2 nRST = 1'b0;
    #1;
    chk("s5_valid", 64'(bus.out_valid), 64'd0);
    chk("s5_occ",   64'(bus.occupancy), 64'd0);
    chk("s5_ready", 64'(bus.in_ready),  64'd1);
    chk("s5_data",  bus.out_data,       64'd0);
    q.delete();
    #1 nRST = 1'b1;
    @(negedge CLK);
    // first edge after release accepts
    cycle(1'b1, 64'h33, 16'h3, 1'b0, 1'b0, 1'b0);
    chk("s5_first_acc", bus.out_data, 64'h33);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) < 6),
            {$urandom, $urandom},
            16'($urandom_range(0, 65535)),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
